spi_flash_word_reader: RTL and testbench

Upstream sequencer for `SPI_Master_With_Single_CS` that fetches one 32-bit little-endian word from a serial flash per request. It uses the standard READ command (0x03) followed by a 24-bit address. It drives the master's byte-level TX interface, consumes its RX byte stream, and discards the header-phase RX bytes. The assembled word is presented to the instruction/data fetch logic with a one-cycle valid pulse.

---
 rtl/spi_flash_pkg.sv | 14 +
 rtl/spi_flash_word_reader.sv | 95 +++++++++
 tb/tb_spi_flash_word_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the serial-flash word reader.
package spi_flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ   = 8'h03;
  localparam logic [3:0] FLASH_HDR_BYTES  = 4'd4;
  localparam logic [3:0] FLASH_WORD_BYTES = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } flash_rd_state_t;

endpackage

// File: rtl/spi_flash_word_reader.sv
// Fetches one little-endian 32-bit word per request via READ + 24-bit address,
// driving the byte-level TX/RX interface of a single-CS SPI master.
module spi_flash_word_reader
  import spi_flash_pkg::*;
#(
  parameter int         MAX_BYTES_PER_CS = 8,
  parameter logic [7:0] CMD_READ         = FLASH_CMD_READ
) (
  input  logic                                    i_Clk,
  input  logic                                    i_Rst_L,
  input  logic                                    i_Req,
  input  logic [23:0]                             i_Addr,
  output logic                                    o_Busy,
  output logic [31:0]                             o_Word,
  output logic                                    o_Word_DV,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0]   o_TX_Count,
  output logic [7:0]                              o_TX_Byte,
  output logic                                    o_TX_DV,
  input  logic                                    i_TX_Ready,
  input  logic                                    i_RX_DV,
  input  logic [7:0]                              i_RX_Byte
);

  localparam int         CNT_W      = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [3:0] XFER_BYTES = FLASH_HDR_BYTES + FLASH_WORD_BYTES;
  localparam logic [3:0] LAST_RX    = XFER_BYTES - 4'd1;

  flash_rd_state_t state;
  logic [23:0]     addr;
  logic [3:0]      tx_idx;
  logic [3:0]      rx_idx;

  assign o_TX_Count = CNT_W'(XFER_BYTES);

  // Command and address bytes first; everything after is dummy clocking for MISO.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [23:0] a);
    if (idx >= FLASH_HDR_BYTES) return 8'h00;
    case (idx[1:0])
      2'd0:    return CMD_READ;
      2'd1:    return a[23:16];
      2'd2:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      addr      <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      o_Busy    <= 1'b0;
      o_Word    <= '0;
      o_Word_DV <= 1'b0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
    end else begin
      o_TX_DV   <= 1'b0;
      o_Word_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Req && i_TX_Ready) begin
            addr   <= i_Addr;
            tx_idx <= '0;
            rx_idx <= '0;
            o_Busy <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          // RX wins over issue; tx_idx==rx_idx keeps a single byte in flight.
          if (i_RX_DV) begin
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx >= FLASH_HDR_BYTES)
              o_Word[8*rx_idx[1:0] +: 8] <= i_RX_Byte;
            if (rx_idx == LAST_RX) begin
              o_Word_DV <= 1'b1;
              state     <= DONE;
            end
          end else if (i_TX_Ready && (tx_idx == rx_idx) && (tx_idx < XFER_BYTES)) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= hdr_byte(tx_idx, addr);
            tx_idx    <= tx_idx + 4'd1;
          end
        end
        DONE: begin
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Bench for spi_flash_word_reader with a behavioural SPI master + flash model
// and a queue-based scoreboard for MOSI bytes and returned words.
module tb_spi_flash_word_reader;
  import spi_flash_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_Req = 1'b0;
  logic [23:0] i_Addr = '0;
  logic        o_Busy;
  logic [31:0] o_Word;
  logic        o_Word_DV;
  logic [3:0]  o_TX_Count;
  logic [7:0]  o_TX_Byte;
  logic        o_TX_DV;
  logic        tx_ready = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;

  spi_flash_word_reader #(.MAX_BYTES_PER_CS(8), .CMD_READ(8'h03)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Req(i_Req), .i_Addr(i_Addr),
    .o_Busy(o_Busy), .o_Word(o_Word), .o_Word_DV(o_Word_DV),
    .o_TX_Count(o_TX_Count), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
    .i_TX_Ready(tx_ready), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_count = 0;
  int tx_seen  = 0;
  int cs_windows = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_mosi[$];
  logic [7:0]  mem [int unsigned];
  logic [7:0]  hdr_fill = 8'hA5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [7:0] mem_rd(input int unsigned a);
    int unsigned k;
    k = a & 32'h00FF_FFFF;
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  // Behavioural master + flash: one byte in flight, 16-cycle byte time, CS gap after 8 bytes.
  int          byte_cnt = 0;
  int          cnt = 0;
  int          gap = 0;
  bit          pending = 0;
  bit          cs_active = 0;
  logic [23:0] cs_addr = '0;
  logic [7:0]  miso = '0;

  always @(negedge clk) begin
    rx_dv = 1'b0;
    if (!rst_n) begin
      tx_ready = 1'b1; byte_cnt = 0; cnt = 0; gap = 0; pending = 0; cs_active = 0;
    end else if (o_TX_DV) begin
      tx_seen++;
      if (!tx_ready) fail_now("tx_dv_while_not_ready");
      if (exp_mosi.size() == 0) fail_now("mosi_unexpected");
      else chk("mosi_byte", {24'h0, o_TX_Byte}, {24'h0, exp_mosi.pop_front()});
      if (!cs_active) begin cs_active = 1; cs_windows++; end
      case (byte_cnt)
        1: cs_addr[23:16] = o_TX_Byte;
        2: cs_addr[15:8]  = o_TX_Byte;
        3: cs_addr[7:0]   = o_TX_Byte;
        default: ;
      endcase
      miso = (byte_cnt < 4) ? hdr_fill : mem_rd(int'(cs_addr) + byte_cnt - 4);
      tx_ready = 1'b0; pending = 1; cnt = 16;
    end else if (pending) begin
      cnt--;
      if (cnt == 0) begin
        pending = 0; rx_dv = 1'b1; rx_byte = miso; byte_cnt++;
        if (byte_cnt == 8) begin byte_cnt = 0; gap = 6; end
        else tx_ready = 1'b1;
      end
    end else if (gap != 0) begin
      gap--;
      if (gap == 0) begin cs_active = 0; tx_ready = 1'b1; end
    end
  end

  // Word monitor
  always @(negedge clk) begin
    if (rst_n && o_Word_DV) begin
      dv_count++;
      chk("busy_at_dv", {31'h0, o_Busy}, 32'h1);
      if (exp_q.size() == 0) fail_now("word_dv_unexpected");
      else chk("word", o_Word, exp_q.pop_front());
    end
  end

  task automatic push_read(input logic [23:0] a, input logic [31:0] w);
    exp_mosi.push_back(8'h03);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
    for (int i = 0; i < 4; i++) exp_mosi.push_back(8'h00);
    exp_q.push_back(w);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k = 0;
    while (o_Busy !== lvl && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) fail_now(name);
  endtask

  task automatic wait_dv(input int target, input string name);
    int k = 0;
    while (dv_count < target && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) fail_now(name);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] w, input string name);
    int base = dv_count;
    push_read(a, w);
    @(negedge clk);
    i_Req = 1'b1; i_Addr = a;
    wait_busy(1'b1, {name, "_accept_timeout"});
    i_Req = 1'b0;
    wait_dv(base + 1, {name, "_dv_timeout"});
    wait_busy(1'b0, {name, "_idle_timeout"});
    chk({name, "_dv_count"}, dv_count - base, 1);
  endtask

  initial begin
    int base, cs_base, k;
    mem[32'hADBEEF] = 8'hDE; mem[32'hADBEF0] = 8'hAD;
    mem[32'hADBEF1] = 8'hBE; mem[32'hADBEF2] = 8'hEF;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    for (int i = 0; i < 4; i++) mem[32'h10 + i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) mem[32'h100 + i] = 8'(8'hC0 + i);
    mem[32'hFFFFFF] = 8'hA1;

    repeat (3) @(negedge clk);
    chk("rst_busy",     {31'h0, o_Busy}, 0);
    chk("rst_word",     o_Word, 0);
    chk("rst_word_dv",  {31'h0, o_Word_DV}, 0);
    chk("rst_tx_dv",    {31'h0, o_TX_DV}, 0);
    chk("rst_tx_byte",  {24'h0, o_TX_Byte}, 0);
    chk("rst_tx_count", {28'h0, o_TX_Count}, 8);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_read(24'hADBEEF, 32'hEFBEADDE, "single");
    repeat (10) @(negedge clk);
    chk("word_held", o_Word, 32'hEFBEADDE);

    hdr_fill = 8'hFF;
    do_read(24'h000100, 32'hC3C2C1C0, "hdr_discard");
    hdr_fill = 8'hA5;

    // Request pulsed mid-transfer must be dropped
    base = dv_count;
    push_read(24'h000010, 32'h04030201);
    @(negedge clk); i_Req = 1'b1; i_Addr = 24'h000010;
    wait_busy(1'b1, "busyreq_accept_timeout");
    i_Req = 1'b0;
    repeat (20) @(negedge clk);
    i_Req = 1'b1; i_Addr = 24'h000100;
    @(negedge clk); i_Req = 1'b0;
    wait_dv(base + 1, "busyreq_dv_timeout");
    repeat (60) @(negedge clk);
    chk("busyreq_dv_count", dv_count - base, 1);
    chk("busyreq_idle", {31'h0, o_Busy}, 0);

    // Back-to-back with i_Req held
    base = dv_count; cs_base = cs_windows;
    push_read(24'h000000, 32'h44332211);
    push_read(24'h000004, 32'h88776655);
    @(negedge clk); i_Req = 1'b1; i_Addr = 24'h000000;
    wait_busy(1'b1, "b2b_accept0_timeout");
    i_Addr = 24'h000004;
    wait_dv(base + 1, "b2b_dv0_timeout");
    wait_busy(1'b0, "b2b_idle0_timeout");
    wait_busy(1'b1, "b2b_accept1_timeout");
    i_Req = 1'b0;
    wait_dv(base + 2, "b2b_dv1_timeout");
    wait_busy(1'b0, "b2b_idle1_timeout");
    chk("b2b_dv_count", dv_count - base, 2);
    chk("b2b_cs_windows", cs_windows - cs_base, 2);

    do_read(24'hFFFFFF, 32'h332211A1, "wrap");

    // Reset in the middle of SEND after three bytes
    push_read(24'h000010, 32'h04030201);
    base = tx_seen;
    @(negedge clk); i_Req = 1'b1; i_Addr = 24'h000010;
    wait_busy(1'b1, "midrst_accept_timeout");
    i_Req = 1'b0;
    k = 0;
    while (tx_seen < base + 3 && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) fail_now("midrst_tx_timeout");
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy",     {31'h0, o_Busy}, 0);
    chk("midrst_word",     o_Word, 0);
    chk("midrst_word_dv",  {31'h0, o_Word_DV}, 0);
    chk("midrst_tx_dv",    {31'h0, o_TX_DV}, 0);
    chk("midrst_tx_byte",  {24'h0, o_TX_Byte}, 0);
    chk("midrst_tx_count", {28'h0, o_TX_Count}, 8);
    exp_q.delete();
    exp_mosi.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(24'h000004, 32'h88776655, "post_reset");

    chk("exp_word_q_empty", exp_q.size(), 0);
    chk("exp_mosi_q_empty", exp_mosi.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
